// File: rtl/piezo_burst_scheduler.sv
// rtl/piezo_burst_scheduler.sv - time-triggered piezo burst sequencer with command queue
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   ptp_time         local PTP time, free-running, wraps modulo 2^32
//   piezo_enable_in  external interlock; low forbids or aborts firing
//   avs_address      register select (0 FIRE_TIME, 1 CH_MASK, 2 CONFIG, 3 PUSH, 4 STATUS, 5 CTRL)
//   avs_write        write strobe
//   avs_writedata    write data
//   avs_read         read strobe
//   avs_readdata     read data, valid the cycle after avs_read
//   piezo_out        per-channel drive
//   piezo_enable     high while a burst is active
//   busy             high when the sequencer is not idle or the queue holds commands
//   burst_done       one-cycle pulse at the end of each completed or aborted burst
module piezo_burst_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int LATE_WINDOW = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       ptp_time,
  input  logic              piezo_enable_in,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] piezo_out,
  output logic              piezo_enable,
  output logic              busy,
  output logic              burst_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // Level needs one more value than the pointer range (0..FIFO_DEPTH), and
  // the STATUS field is 5 bits wide, which covers the largest depth of 16.
  localparam int LVW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  state_t state;

  // Staging registers written by software, copied into the queue on PUSH.
  logic [31:0]       stg_fire;
  logic [NUM_CH-1:0] stg_mask;
  logic [31:0]       stg_cfg;

  // Command queue storage.
  logic [31:0]       q_fire [FIFO_DEPTH];
  logic [NUM_CH-1:0] q_mask [FIFO_DEPTH];
  logic [31:0]       q_cfg  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LVW-1:0]    level;

  // Working copy of the command being executed.
  logic [31:0]       w_fire;
  logic [NUM_CH-1:0] w_mask;
  logic [15:0]       w_half;
  logic [15:0]       w_count;
  logic [15:0]       cyc_cnt;
  logic [15:0]       pulse_cnt;

  logic sticky_ovf;
  logic sticky_late;
  logic sticky_abt;

  logic        wr_push;
  logic        wr_ctrl;
  logic        ctrl_abort;
  logic        ctrl_clear;
  logic        q_empty;
  logic        q_full;
  logic        do_pop;
  logic        do_push;
  logic        in_burst;
  logic        ovf_set;
  logic        late_set;
  logic        abt_set;
  logic [15:0] head_half;
  logic [15:0] head_count;
  logic [31:0] diff;
  logic        due;
  logic        late;
  logic [31:0] rd_mux;

  assign wr_push    = avs_write && (avs_address == 3'd3);
  assign wr_ctrl    = avs_write && (avs_address == 3'd5);
  assign ctrl_abort = wr_ctrl && avs_writedata[0];
  assign ctrl_clear = wr_ctrl && avs_writedata[1];

  assign q_empty = (level == '0);
  assign q_full  = (level == LVW'(FIFO_DEPTH));
  assign do_pop  = (state == S_IDLE) && !q_empty && !ctrl_abort;
  // A pop in the same cycle frees the slot, so a push into a full queue is
  // still accepted then. An abort flushes everything, including this push.
  assign do_push = wr_push && !ctrl_abort && (!q_full || do_pop);

  assign in_burst = (state == S_HIGH) || (state == S_LOW);

  assign head_half  = q_cfg[rd_ptr][15:0];
  assign head_count = q_cfg[rd_ptr][31:16];

  // Modular difference read as signed keeps the comparison correct across
  // the 2^32 wrap of ptp_time.
  assign diff = ptp_time - w_fire;
  assign due  = !diff[31];
  assign late = $signed(diff) > $signed(32'(LATE_WINDOW));

  assign ovf_set  = wr_push && !ctrl_abort && q_full && !do_pop;
  assign late_set = (state == S_WAIT) && late && !ctrl_abort;
  assign abt_set  = ctrl_abort || (in_burst && !piezo_enable_in);

  assign busy = (state != S_IDLE) || !q_empty;

  // Queue pointers and level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (ctrl_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (!do_push && do_pop)
        level <= level - 1'b1;
    end
  end

  // Queue storage carries no reset; the level alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_fire[wr_ptr] <= stg_fire;
      q_mask[wr_ptr] <= stg_mask;
      q_cfg[wr_ptr]  <= stg_cfg;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux = stg_fire;
      3'd1: rd_mux[NUM_CH-1:0] = stg_mask;
      3'd2: rd_mux = stg_cfg;
      3'd4: begin
        rd_mux[LVW-1:0] = level;
        rd_mux[9:8]     = state;
        rd_mux[16]      = sticky_ovf;
        rd_mux[17]      = sticky_late;
        rd_mux[18]      = sticky_abt;
      end
      default: rd_mux = '0;
    endcase
  end

  // Register file: staging, sticky flags and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_fire     <= '0;
      stg_mask     <= '0;
      stg_cfg      <= '0;
      sticky_ovf   <= 1'b0;
      sticky_late  <= 1'b0;
      sticky_abt   <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          3'd0:    stg_fire <= avs_writedata;
          3'd1:    stg_mask <= avs_writedata[NUM_CH-1:0];
          3'd2:    stg_cfg  <= avs_writedata;
          default: ;
        endcase
      end
      // A new event in the same cycle as a clear wins, so it is not lost.
      if (ctrl_clear) begin
        sticky_ovf  <= 1'b0;
        sticky_late <= 1'b0;
        sticky_abt  <= 1'b0;
      end
      if (ovf_set)  sticky_ovf  <= 1'b1;
      if (late_set) sticky_late <= 1'b1;
      if (abt_set)  sticky_abt  <= 1'b1;
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

  // Burst sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      w_fire       <= '0;
      w_mask       <= '0;
      w_half       <= '0;
      w_count      <= '0;
      cyc_cnt      <= '0;
      pulse_cnt    <= '0;
      piezo_out    <= '0;
      piezo_enable <= 1'b0;
      burst_done   <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (ctrl_abort) begin
        state        <= S_IDLE;
        piezo_out    <= '0;
        piezo_enable <= 1'b0;
        burst_done   <= in_burst;
      end else begin
        case (state)
          S_IDLE: begin
            if (do_pop) begin
              w_fire  <= q_fire[rd_ptr];
              w_mask  <= q_mask[rd_ptr];
              w_half  <= head_half;
              w_count <= head_count;
              // Degenerate commands are dropped here and never reach WAIT.
              if (head_half != 16'd0 && head_count != 16'd0)
                state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (late) begin
              state <= S_IDLE;
            end else if (due && piezo_enable_in) begin
              state        <= S_HIGH;
              cyc_cnt      <= w_half;
              pulse_cnt    <= w_count;
              piezo_out    <= w_mask;
              piezo_enable <= 1'b1;
            end
          end
          S_HIGH: begin
            if (!piezo_enable_in) begin
              state        <= S_IDLE;
              piezo_out    <= '0;
              piezo_enable <= 1'b0;
              burst_done   <= 1'b1;
            end else if (cyc_cnt == 16'd1) begin
              state     <= S_LOW;
              cyc_cnt   <= w_half;
              piezo_out <= '0;
            end else begin
              cyc_cnt <= cyc_cnt - 16'd1;
            end
          end
          S_LOW: begin
            if (!piezo_enable_in) begin
              state        <= S_IDLE;
              piezo_out    <= '0;
              piezo_enable <= 1'b0;
              burst_done   <= 1'b1;
            end else if (cyc_cnt == 16'd1) begin
              if (pulse_cnt == 16'd1) begin
                state        <= S_IDLE;
                pulse_cnt    <= '0;
                piezo_enable <= 1'b0;
                burst_done   <= 1'b1;
              end else begin
                state     <= S_HIGH;
                pulse_cnt <= pulse_cnt - 16'd1;
                cyc_cnt   <= w_half;
                piezo_out <= w_mask;
              end
            end else begin
              cyc_cnt <= cyc_cnt - 16'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piezo_burst_scheduler.sv
// tb/tb_piezo_burst_scheduler.sv - directed and randomized bench against a behavioural burst model
module tb_piezo_burst_scheduler;

  localparam int NUM_CH      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int LATE_WINDOW = 1000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       ptp_time;
  logic              piezo_enable_in;
  logic [2:0]        avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] piezo_out;
  logic              piezo_enable;
  logic              busy;
  logic              burst_done;

  always #5 clk = ~clk;

  piezo_burst_scheduler #(
    .NUM_CH(NUM_CH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LATE_WINDOW(LATE_WINDOW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ptp_time(ptp_time),
    .piezo_enable_in(piezo_enable_in),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .piezo_out(piezo_out),
    .piezo_enable(piezo_enable),
    .busy(busy),
    .burst_done(burst_done)
  );

  typedef struct {
    logic [31:0] fire;
    logic [31:0] mask;
    int          half;
    int          cnt;
  } cmd_t;

  // Behavioural model: a queue of commands, one pending command waiting for
  // its time, and a firing command described by the cycles elapsed since it
  // started. The output waveform is derived from elapsed / half.
  cmd_t        mq[$];
  cmd_t        cur;
  bit          m_pending;
  bit          m_firing;
  int          m_e;
  bit          m_ovf, m_late, m_abt;
  logic [31:0] m_fire_stg, m_mask_stg, m_cfg_stg;
  logic [31:0] exp_out;
  bit          exp_en, exp_done, exp_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cycles = 0;
  int hi_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[4:0] = 5'(mq.size());
    if (m_firing)
      s[9:8] = ((m_e / cur.half) % 2 == 0) ? 2'd2 : 2'd3;
    else if (m_pending)
      s[9:8] = 2'd1;
    s[16] = m_ovf;
    s[17] = m_late;
    s[18] = m_abt;
    return s;
  endfunction

  function automatic logic [31:0] m_readback(input logic [2:0] a);
    case (a)
      3'd0:    return m_fire_stg;
      3'd1:    return m_mask_stg;
      3'd2:    return m_cfg_stg;
      3'd4:    return m_status();
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pending = 0; m_firing = 0; m_e = 0;
    m_ovf = 0; m_late = 0; m_abt = 0;
    m_fire_stg = '0; m_mask_stg = '0; m_cfg_stg = '0;
    exp_out = '0; exp_en = 0; exp_done = 0; exp_busy = 0;
    cur.fire = '0; cur.mask = '0; cur.half = 1; cur.cnt = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit          abort, clr, push;
    logic [31:0] diff;
    cmd_t        c;
    abort = avs_write && avs_address == 3'd5 && avs_writedata[0];
    clr   = avs_write && avs_address == 3'd5 && avs_writedata[1];
    push  = avs_write && avs_address == 3'd3;
    exp_done = 0;
    if (clr) begin
      m_ovf = 0; m_late = 0; m_abt = 0;
    end
    if (abort) begin
      if (m_firing) exp_done = 1;
      m_abt = 1;
      mq.delete();
      m_pending = 0;
      m_firing = 0;
    end else begin
      if (m_firing) begin
        if (!piezo_enable_in) begin
          m_firing = 0; m_abt = 1; exp_done = 1;
        end else begin
          m_e++;
          if (longint'(m_e) == longint'(2) * cur.half * cur.cnt) begin
            m_firing = 0; exp_done = 1;
          end
        end
      end else if (m_pending) begin
        diff = ptp_time - cur.fire;
        if ($signed(diff) > LATE_WINDOW) begin
          m_pending = 0; m_late = 1;
        end else if (!diff[31] && piezo_enable_in) begin
          m_pending = 0; m_firing = 1; m_e = 0;
        end
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        m_pending = (cur.half != 0) && (cur.cnt != 0);
      end
      if (push) begin
        if (mq.size() < FIFO_DEPTH) begin
          c.fire = m_fire_stg;
          c.mask = m_mask_stg;
          c.half = int'(m_cfg_stg[15:0]);
          c.cnt  = int'(m_cfg_stg[31:16]);
          mq.push_back(c);
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (avs_write) begin
      case (avs_address)
        3'd0: m_fire_stg = avs_writedata;
        3'd1: m_mask_stg = avs_writedata & 32'h0000_00FF;
        3'd2: m_cfg_stg  = avs_writedata;
        default: ;
      endcase
    end
    exp_en   = m_firing;
    exp_out  = (m_firing && ((m_e / cur.half) % 2 == 0)) ? cur.mask : 32'd0;
    exp_busy = m_firing || m_pending || (mq.size() > 0);
  endtask

  task automatic tick();
    bit          rd_was;
    logic [31:0] rd_exp;
    rd_was = avs_read;
    rd_exp = m_readback(avs_address);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("piezo_out", 32'(piezo_out), exp_out);
    check("piezo_enable", 32'(piezo_enable), 32'(exp_en));
    check("burst_done", 32'(burst_done), 32'(exp_done));
    check("busy", 32'(busy), 32'(exp_busy));
    if (rd_was) check("readdata", avs_readdata, rd_exp);
    if (piezo_enable) en_cycles++;
    if (piezo_out != '0) hi_cycles++;
    avs_write = 0;
    avs_read  = 0;
    ptp_time  = ptp_time + 32'd1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1;
    tick();
    d = avs_readdata;
  endtask

  task automatic queue_cmd(input logic [31:0] fire, input logic [31:0] mask,
                           input logic [15:0] half, input logic [15:0] cnt);
    wr(3'd0, fire);
    wr(3'd1, mask);
    wr(3'd2, {cnt, half});
    wr(3'd3, 32'd0);
  endtask

  task automatic wait_done(input int max, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (burst_done) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_en(input int max, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (piezo_enable) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] st;
    bit          early;
    int          r;

    avs_address = '0; avs_write = 0; avs_writedata = '0; avs_read = 0;
    ptp_time = '0; piezo_enable_in = 1; reset_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_piezo_out", 32'(piezo_out), 32'd0);
    check("rst_piezo_enable", 32'(piezo_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1;
    tick();
    rd(3'd4, st);
    check("rst_status", st, 32'd0);

    // Basic burst: 3 periods of 4 high / 4 low on channels 0 and 2.
    ptp_time = 32'd900;
    queue_cmd(32'd1000, 32'h05, 16'd4, 16'd3);
    en_cycles = 0; hi_cycles = 0;
    wait_done(400, "t1_done");
    check("t1_en_cycles", 32'(en_cycles), 32'd24);
    check("t1_hi_cycles", 32'(hi_cycles), 32'd12);

    // Fire time just past the 2^32 wrap.
    ptp_time = 32'hFFFF_FFF0;
    queue_cmd(32'h0000_0010, 32'h0A, 16'd1, 16'd2);
    early = 0;
    for (int i = 0; i < 60 && !burst_done; i++) begin
      tick();
      if (piezo_enable && ptp_time[31]) early = 1;
    end
    check("t2_no_early_fire", 32'(early), 32'd0);
    check("t2_done", 32'(burst_done), 32'd1);

    // Late command: discarded, late flag set, no activity.
    ptp_time = 32'd2000;
    en_cycles = 0;
    queue_cmd(32'd100, 32'hFF, 16'd1, 16'd2);
    repeat (3) tick();
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_en_cycles", 32'(en_cycles), 32'd0);
    rd(3'd4, st);
    check("t3_late", 32'(st[17]), 32'd1);
    wr(3'd5, 32'd2);

    // Overflow: head waits in WAIT, four more fill the queue, sixth drops.
    ptp_time = 32'd5000;
    wr(3'd0, 32'd100000);
    wr(3'd1, 32'h01);
    wr(3'd2, {16'd1, 16'd1});
    repeat (5) wr(3'd3, 32'd0);
    rd(3'd4, st);
    check("t4_level5", 32'(st[4:0]), 32'd4);
    check("t4_ovf5", 32'(st[16]), 32'd0);
    wr(3'd3, 32'd0);
    rd(3'd4, st);
    check("t4_level6", 32'(st[4:0]), 32'd4);
    check("t4_ovf6", 32'(st[16]), 32'd1);
    wr(3'd5, 32'd1);
    wr(3'd5, 32'd2);

    // Interlock drop in pulse 2 of 3; queued next command still fires.
    ptp_time = 32'd10000;
    queue_cmd(32'd10020, 32'h3C, 16'd3, 16'd3);
    queue_cmd(32'd10100, 32'h81, 16'd2, 16'd2);
    wait_en(100, "t5_start");
    repeat (7) tick();
    piezo_enable_in = 0;
    tick();
    piezo_enable_in = 1;
    check("t5_out_zero", 32'(piezo_out), 32'd0);
    check("t5_done_pulse", 32'(burst_done), 32'd1);
    rd(3'd4, st);
    check("t5_aborted", 32'(st[18]), 32'd1);
    wait_en(200, "t5_next_start");
    en_cycles = 1;
    wait_done(100, "t5_next_done");
    check("t5_next_en_cycles", 32'(en_cycles), 32'd8);
    wr(3'd5, 32'd2);

    // CTRL abort with one active and three queued.
    ptp_time = 32'd20000;
    queue_cmd(32'd20010, 32'hFF, 16'd50, 16'd5);
    queue_cmd(32'd30000, 32'h11, 16'd2, 16'd2);
    wr(3'd3, 32'd0);
    wr(3'd3, 32'd0);
    wait_en(100, "t6_start");
    repeat (5) tick();
    wr(3'd5, 32'd1);
    check("t6_out_zero", 32'(piezo_out), 32'd0);
    check("t6_done_pulse", 32'(burst_done), 32'd1);
    rd(3'd4, st);
    check("t6_level", 32'(st[4:0]), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    wr(3'd5, 32'd2);
    rd(3'd4, st);
    check("t6_sticky_clear", 32'(st[18:16]), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        if (r == 0) wr(3'd0, ptp_time - 32'd1200);
        else        wr(3'd0, ptp_time + $urandom_range(0, 40) - 32'd10);
      end else if (r < 9) begin
        wr(3'd1, $urandom);
      end else if (r < 12) begin
        wr(3'd2, {16'($urandom_range(0, 3)), 16'($urandom_range(0, 4))});
      end else if (r < 20) begin
        wr(3'd3, $urandom);
      end else if (r < 21) begin
        wr(3'd5, ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd2);
      end else if (r < 28) begin
        avs_address = 3'($urandom_range(0, 7));
        avs_read = 1;
        tick();
      end else begin
        if (piezo_enable_in && $urandom_range(0, 79) == 0) piezo_enable_in = 0;
        else if (!piezo_enable_in && $urandom_range(0, 3) == 0) piezo_enable_in = 1;
        tick();
      end
    end

    piezo_enable_in = 1;
    for (int i = 0; i < 3000 && busy; i++) tick();
    check("drain_busy", 32'(busy), 32'd0);
    rd(3'd4, st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
